// File: rtl/traffic_intersection_ctrl.sv
// Two-phase (NS/EW) intersection controller: green -> yellow -> all-red per direction,
// with latched pedestrian requests, a timed walk window and early green cut-off.
module traffic_intersection_ctrl #(
  parameter int T_GREEN     = 60,
  parameter int T_MIN_GREEN = 10,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 8,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    CLR_A = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    CLR_B = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(T_WALK - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend_ns, pend_ns_nxt, pend_ew, pend_ew_nxt;
  logic             walk_ns_nxt, walk_ew_nxt;
  logic             enter_ns, enter_ew;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLR_A;
      cnt     <= '0;
      pend_ns <= 1'b0;
      pend_ew <= 1'b0;
      walk_ns <= 1'b0;
      walk_ew <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_ns <= pend_ns_nxt;
      pend_ew <= pend_ew_nxt;
      walk_ns <= walk_ns_nxt;
      walk_ew <= walk_ew_nxt;
    end
  end

  // A green is cut short only once min-green has elapsed and its own walk window is over
  always_comb begin
    state_nxt = state;
    case (state)
      CLR_A: if (cnt == AR_LAST) state_nxt = NS_G;
      NS_G:  if (cnt == G_LAST || (pend_ew && cnt >= MG_LAST && !walk_ns)) state_nxt = NS_Y;
      NS_Y:  if (cnt == Y_LAST) state_nxt = CLR_B;
      CLR_B: if (cnt == AR_LAST) state_nxt = EW_G;
      EW_G:  if (cnt == G_LAST || (pend_ns && cnt >= MG_LAST && !walk_ew)) state_nxt = EW_Y;
      EW_Y:  if (cnt == Y_LAST) state_nxt = CLR_A;
      default: state_nxt = CLR_A;
    endcase
  end

  always_comb begin
    enter_ns = (state_nxt == NS_G) && (state != NS_G);
    enter_ew = (state_nxt == EW_G) && (state != EW_G);
    cnt_nxt  = (state_nxt != state) ? '0 : cnt + 1'b1;

    // Requests seen on the entry edge are served by this green; during walk they are absorbed
    pend_ns_nxt = pend_ns;
    walk_ns_nxt = walk_ns;
    if (enter_ns) begin
      pend_ns_nxt = 1'b0;
      walk_ns_nxt = pend_ns | ped_req_ns;
    end else begin
      if (!walk_ns) pend_ns_nxt = pend_ns | ped_req_ns;
      if (state_nxt != NS_G || cnt == W_LAST) walk_ns_nxt = 1'b0;
    end

    pend_ew_nxt = pend_ew;
    walk_ew_nxt = walk_ew;
    if (enter_ew) begin
      pend_ew_nxt = 1'b0;
      walk_ew_nxt = pend_ew | ped_req_ew;
    end else begin
      if (!walk_ew) pend_ew_nxt = pend_ew | ped_req_ew;
      if (state_nxt != EW_G || cnt == W_LAST) walk_ew_nxt = 1'b0;
    end
  end

  assign ns_green  = (state == NS_G);
  assign ns_yellow = (state == NS_Y);
  assign ns_red    = !(ns_green || ns_yellow);
  assign ew_green  = (state == EW_G);
  assign ew_yellow = (state == EW_Y);
  assign ew_red    = !(ew_green || ew_yellow);
  assign phase     = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench for traffic_intersection_ctrl: a behavioural model predicts every
// cycle's outputs, which are queued at the clock edge and compared on the falling edge.
module tb_traffic_intersection_ctrl;

  localparam int G = 8, MG = 4, Y = 2, AR = 1, W = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req_ns = 1'b0;
  logic       ped_req_ew = 1'b0;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic       walk_ns, walk_ew;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  logic [10:0] sb[$];
  logic [10:0] exp_v;

  int m_ph, m_t, m_wns, m_wew;
  bit m_pns, m_pew;

  always #5 clk = ~clk;

  traffic_intersection_ctrl #(
    .T_GREEN(G), .T_MIN_GREEN(MG), .T_YELLOW(Y), .T_ALLRED(AR), .T_WALK(W), .CNT_W(7)
  ) dut (
    .clk(clk), .rst(rst), .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk_ns(walk_ns), .walk_ew(walk_ew), .phase(phase)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] model_out();
    logic [2:0] p;
    p = 3'(m_ph);
    return {p,
            !(m_ph == 1 || m_ph == 2), m_ph == 2, m_ph == 1,
            !(m_ph == 4 || m_ph == 5), m_ph == 5, m_ph == 4,
            m_wns > 0, m_wew > 0};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_wns = 0; m_wew = 0; m_pns = 0; m_pew = 0;
  endtask

  task automatic model_step(input bit rn, input bit re);
    int lim;
    bit leave;
    int nph;
    case (m_ph)
      0, 3:    lim = AR;
      1, 4:    lim = G;
      default: lim = Y;
    endcase
    leave = (m_t == lim - 1)
         || (m_ph == 1 && m_pew && m_t >= MG - 1 && m_wns == 0)
         || (m_ph == 4 && m_pns && m_t >= MG - 1 && m_wew == 0);
    nph = leave ? (m_ph + 1) % 6 : m_ph;
    if (nph == 1 && m_ph != 1) begin
      m_wns = (m_pns || rn) ? W : 0;
      m_pns = 0;
    end else begin
      if (m_wns == 0) m_pns = m_pns | rn;
      if (m_wns > 0) m_wns--;
    end
    if (nph == 4 && m_ph != 4) begin
      m_wew = (m_pew || re) ? W : 0;
      m_pew = 0;
    end else begin
      if (m_wew == 0) m_pew = m_pew | re;
      if (m_wew > 0) m_wew--;
    end
    m_t  = leave ? 0 : m_t + 1;
    m_ph = nph;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      chk("cycle_outputs",
          32'({phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk_ns, walk_ew}),
          32'(exp_v));
    end
  end

  task automatic step();
    @(posedge clk);
    model_step(ped_req_ns, ped_req_ew);
    sb.push_back(model_out());
    #1;
  endtask

  task automatic run_until(input int ph, input int t, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (m_ph == ph && m_t == t) found = 1;
    end
    chk($sformatf("reach_ph%0d_t%0d", ph, t), 32'(found), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_lamps", 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), 32'h24);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_walk", 32'({walk_ns, walk_ew}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_phase", 32'(phase), 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wcnt;
    model_reset();

    // idle cycling, two full periods
    do_reset();
    repeat (44) step();

    // single EW pulse at NS_G counter 1 cuts the NS green to 4 cycles
    run_until(1, 1, 30);
    ped_req_ew = 1'b1;
    step();
    ped_req_ew = 1'b0;
    step();
    chk("t2_nsg_cnt3", 32'(phase), 32'd1);
    step();
    chk("t2_nsy_entry", 32'(phase), 32'd2);
    step();
    step();
    chk("t2_clrb", 32'(phase), 32'd3);
    step();
    chk("t2_ewg_walk", 32'({phase, walk_ew}), 32'h9);
    step();
    step();
    chk("t2_walk_last", 32'(walk_ew), 32'd1);
    step();
    chk("t2_walk_end", 32'(walk_ew), 32'd0);
    repeat (10) step();

    // NS request held high from reset
    ped_req_ns = 1'b1;
    do_reset();
    repeat (50) step();
    ped_req_ns = 1'b0;

    // pulse in CLR_A, then a second pulse during walk that must be absorbed
    do_reset();
    ped_req_ns = 1'b1;
    step();
    wcnt = int'(walk_ns);
    for (int i = 0; i < 20; i++) begin
      ped_req_ns = (m_ph == 1 && m_t == 1);
      step();
      wcnt += int'(walk_ns);
    end
    ped_req_ns = 1'b0;
    chk("t4_walk_len", 32'(wcnt), 32'd3);
    repeat (10) step();

    // both requests together during EW_Y
    run_until(5, 0, 30);
    ped_req_ns = 1'b1;
    ped_req_ew = 1'b1;
    step();
    ped_req_ns = 1'b0;
    ped_req_ew = 1'b0;
    repeat (40) step();

    // asynchronous reset in the middle of EW_G
    run_until(4, 5, 40);
    do_reset();
    step();
    chk("t6_nsg_after_clr", 32'(phase), 32'd1);
    repeat (6) step();

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
